rvvi_retire_sched: RTL

Retirement scheduler for the functional-coverage trace path. It collects retired-instruction records from NREQ independent producers: trace-replay channels, or harts in a multi-hart run. It shares the single RVVI retire slot among them with round-robin arbitration and buffers granted records in a small FIFO. Each record is stamped with a monotonically increasing order number before it drives the RVVI trace interface that feeds `cvw_arch_verif`.

---
 rtl/rvvi_sched_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/rvvi_retire_sched.sv | 102 ++++++++++
 3 files changed

// File: rtl/rvvi_sched_pkg.sv
// Shared types for the RVVI retirement scheduler: the retired-instruction record
// and the reset value of the order stamp.
package rvvi_sched_pkg;

  localparam int unsigned XLEN = 64;
  localparam logic [63:0] ORDER_RESET = 64'd1;

  typedef struct packed {
    logic [31:0]     insn;
    logic [XLEN-1:0] pc;
    logic            trap;
    logic [1:0]      mode;
    logic            x_wb;
    logic [4:0]      x_idx;
    logic [XLEN-1:0] x_wdata;
  } retire_rec_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or above rr, wrapping; one-hot
// gnt plus its index, both zero when en is low or nothing is requested.
module rr_arbiter #(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic [IW-1:0]   rr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gidx
);

  logic          w_found;
  logic [IW-1:0] w_idx;

  always_comb begin
    gnt     = '0;
    gidx    = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_idx = IW'((32'(rr) + i) % NREQ);
      if (en && !w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        gidx       = w_idx;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rvvi_retire_sched.sv
// Shares the single RVVI retire slot among NREQ producers: round-robin grant,
// order stamping and a DEPTH-entry output FIFO.
module rvvi_retire_sched
  import rvvi_sched_pkg::*;
#(
  parameter  int unsigned NREQ  = 2,
  parameter  int unsigned XLEN  = 64,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned SW    = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  retire_rec_t [NREQ-1:0]  req_rec,
  output logic [NREQ-1:0]         req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output retire_rec_t             out_rec,
  output logic [63:0]             out_order,
  output logic [SW-1:0]           out_src,
  output logic [CW-1:0]           count,
  output logic                    idle
);

  localparam int unsigned PW = $clog2(DEPTH);

  if (XLEN != rvvi_sched_pkg::XLEN) begin : g_xlen_chk
    $error("XLEN must match rvvi_sched_pkg::XLEN");
  end

  logic [NREQ-1:0] w_gnt;
  logic [SW-1:0]   w_gidx;
  logic            w_pop;
  logic            w_push;
  logic            w_en;

  retire_rec_t     r_mem_rec   [DEPTH];
  logic [63:0]     r_mem_order [DEPTH];
  logic [SW-1:0]   r_mem_src   [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [SW-1:0]   r_rr;
  logic [63:0]     r_order;

  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid & out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_en      = ~reset & ((r_count != CW'(DEPTH)) | w_pop);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req  (req_valid),
    .en   (w_en),
    .rr   (r_rr),
    .gnt  (w_gnt),
    .gidx (w_gidx)
  );

  assign req_ready = w_gnt;
  assign w_push    = |w_gnt;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rec[r_wptr]   <= req_rec[w_gidx];
      r_mem_order[r_wptr] <= r_order;
      r_mem_src[r_wptr]   <= w_gidx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rr    <= '0;
      r_order <= ORDER_RESET;
    end else begin
      if (w_push) begin
        r_wptr  <= r_wptr + PW'(1);
        r_order <= r_order + 64'd1;
        r_rr    <= (w_gidx == SW'(NREQ - 1)) ? '0 : w_gidx + SW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Storage is not reset; gating the head with out_valid gives all-zero outputs when empty.
  assign out_rec   = out_valid ? r_mem_rec[r_rptr]   : '0;
  assign out_order = out_valid ? r_mem_order[r_rptr] : '0;
  assign out_src   = out_valid ? r_mem_src[r_rptr]   : '0;
  assign count     = r_count;
  assign idle      = (r_count == '0) & ~|req_valid;

endmodule
